muldiv_unit: RTL

Iterative multiply/divide sequencer for the MIPS32 core, executing MULT, MULTU, DIV and DIVU and owning the architectural HI/LO registers. It sits beside the ALU in the execute stage. The decode/hazard logic launches an operation with a one-cycle `start` strobe and stalls on `busy` before any MFHI/MFLO. Operands come from the same A/B operand muxes that feed the ALU. One shift/add-subtract step is performed per cycle.

---
 rtl/muldiv_unit_pkg.sv | 28 ++
 rtl/muldiv_unit_if.sv | 26 ++
 rtl/muldiv_unit_datapath.sv | 120 ++++++++++++
 rtl/muldiv_unit.sv | 121 ++++++++++++
 4 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared types for the MIPS32 multiply/divide sequencer: op encodings and FSM states.
package muldiv_unit_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FIX,
    ST_DONE
  } md_state_e;

  localparam int unsigned MD_WIDTH = 32;

  function automatic logic op_is_div(md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic op_is_signed(md_op_e op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Launch/result bundle between execute-stage control and the multiply/divide sequencer.
interface muldiv_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             mthi;
  logic             mtlo;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, mthi, mtlo, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, mthi, mtlo, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_unit_datapath.sv
// Accumulator/shift pair, one shift-add or restoring shift-subtract step per cycle, and sign fix-up.
// Divide hardware is only present when MULDIV_DIV_EN is defined.
module muldiv_datapath
  import muldiv_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic             fix,
  input  md_op_e           op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] opd_q, opd_d;
  logic             neg_res_q, neg_res_d;
  logic [WIDTH:0]   sum;
  logic             a_neg, b_neg;
`ifdef MULDIV_DIV_EN
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic             is_div_q, is_div_d;
  logic             neg_rem_q, neg_rem_d;
  logic             div_zero_q, div_zero_d;
  logic [WIDTH:0]   rsh, diff;
  logic             ge;
`endif

  always_comb begin
    acc_d     = acc_q;
    sh_d      = sh_q;
    opd_d     = opd_q;
    neg_res_d = neg_res_q;
    a_neg     = op_is_signed(op) & a[WIDTH-1];
    b_neg     = op_is_signed(op) & b[WIDTH-1];
    sum       = {1'b0, acc_q} + {1'b0, opd_q};
`ifdef MULDIV_DIV_EN
    dvd_d      = dvd_q;
    is_div_d   = is_div_q;
    neg_rem_d  = neg_rem_q;
    div_zero_d = div_zero_q;
    rsh        = {acc_q, sh_q[WIDTH-1]};
    diff       = rsh - {1'b0, opd_q};
    ge         = (rsh >= {1'b0, opd_q});
`endif
    if (load) begin
      acc_d     = '0;
      sh_d      = a_neg ? -a : a;
      opd_d     = b_neg ? -b : b;
      neg_res_d = a_neg ^ b_neg;
`ifdef MULDIV_DIV_EN
      dvd_d      = a;
      is_div_d   = op_is_div(op);
      neg_rem_d  = a_neg;
      div_zero_d = (b == '0);
`endif
    end else if (step) begin
`ifdef MULDIV_DIV_EN
      // acc holds the partial remainder, sh shifts dividend bits out and quotient bits in
      if (is_div_q) begin
        acc_d = ge ? diff[WIDTH-1:0] : rsh[WIDTH-1:0];
        sh_d  = {sh_q[WIDTH-2:0], ge};
      end else
`endif
      begin
        acc_d = sh_q[0] ? sum[WIDTH:1] : {1'b0, acc_q[WIDTH-1:1]};
        sh_d  = {(sh_q[0] ? sum[0] : acc_q[0]), sh_q[WIDTH-1:1]};
      end
    end else if (fix) begin
`ifdef MULDIV_DIV_EN
      if (is_div_q) begin
        if (div_zero_q) begin
          acc_d = dvd_q;
          sh_d  = '1;
        end else begin
          if (neg_res_q) sh_d = -sh_q;
          if (neg_rem_q) acc_d = -acc_q;
        end
      end else
`endif
      if (neg_res_q) {acc_d, sh_d} = -{acc_q, sh_q};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q      <= '0;
      sh_q       <= '0;
      opd_q      <= '0;
      neg_res_q  <= 1'b0;
`ifdef MULDIV_DIV_EN
      dvd_q      <= '0;
      is_div_q   <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
`endif
    end else begin
      acc_q      <= acc_d;
      sh_q       <= sh_d;
      opd_q      <= opd_d;
      neg_res_q  <= neg_res_d;
`ifdef MULDIV_DIV_EN
      dvd_q      <= dvd_d;
      is_div_q   <= is_div_d;
      neg_rem_q  <= neg_rem_d;
      div_zero_q <= div_zero_d;
`endif
    end
  end

  assign res_hi = acc_q;
  assign res_lo = sh_q;

endmodule

// File: rtl/muldiv_unit.sv
// MULT/MULTU/DIV/DIVU sequencer owning HI/LO: FSM, step counter, MTHI/MTLO and handshake.
// Define MULDIV_DIV_EN to build the divide path; otherwise DIV/DIVU keep timing but leave HI/LO alone.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input logic          clock,
  input logic          reset,
  muldiv_unit_if.slave bus
);

  localparam int unsigned          CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(WIDTH - 1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
  logic             load, step, fix, wr_res;
  logic [WIDTH-1:0] res_hi, res_lo;
`ifndef MULDIV_DIV_EN
  md_op_e           op_q, op_d;
`endif

`ifdef MULDIV_DIV_EN
  assign wr_res = 1'b1;
`else
  assign wr_res = !op_is_div(op_q);
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    load    = 1'b0;
    step    = 1'b0;
    fix     = 1'b0;
`ifndef MULDIV_DIV_EN
    op_d    = op_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (bus.mthi) hi_d = bus.wdata;
        if (bus.mtlo) lo_d = bus.wdata;
        if (bus.start) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = ST_RUN;
`ifndef MULDIV_DIV_EN
          op_d    = md_op_e'(bus.op);
`endif
        end
      end
      ST_RUN: begin
        step  = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = ST_FIX;
      end
      ST_FIX: begin
        fix     = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        // done is registered so it rises together with the HI/LO write and busy falling
        done_d  = 1'b1;
        state_d = ST_IDLE;
        if (wr_res) begin
          hi_d = res_hi;
          lo_d = res_lo;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
`ifndef MULDIV_DIV_EN
      op_q    <= MD_MULT;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
`ifndef MULDIV_DIV_EN
      op_q    <= op_d;
`endif
    end
  end

  muldiv_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clock (clock),
    .reset (reset),
    .load  (load),
    .step  (step),
    .fix   (fix),
    .op    (md_op_e'(bus.op)),
    .a     (bus.a),
    .b     (bus.b),
    .res_hi(res_hi),
    .res_lo(res_lo)
  );

  assign bus.busy = (state_q != ST_IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule
